// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin decoded-resource arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } arb_state_e;

  // First requester found when searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  function automatic logic [1:0] next_owner(input logic [N_REQ-1:0] req,
                                            input logic [1:0]       ptr);
    logic [1:0] idx;
    logic [1:0] sel;
    logic       found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/dec2to4_en.sv
// Enabled 2-to-4 one-hot decoder driving the shared select lines.
module dec2to4_en (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  always_comb begin
    y = '0;
    if (en) y = 4'b0001 << sel;
  end

endmodule

// File: rtl/rr_dec_arbiter.sv
// 4-way round-robin arbiter with bounded hold time, one-cycle bus turnaround
// and a decoded one-hot grant.
module rr_dec_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [1:0]       gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  arb_state_e       state_q, state_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    sel       = next_owner(req, ptr_q);
    case (state_q)
      IDLE: begin
        if (en && (req != '0)) begin
          gnt_id_d = sel;
          cnt_d    = '0;
          ptr_d    = sel + 2'd1;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        // Disable or owner drop wins over an expiring hold: no timeout pulse then.
        if (!en || !req[gnt_id_q]) begin
          state_d = GAP;
        end else if (cnt_q >= CNT_W'(MAX_HOLD - 1)) begin
          state_d   = GAP;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign gnt_valid = (state_q == GRANT);
  assign gnt_id    = gnt_id_q;
  assign timeout   = timeout_q;

  dec2to4_en u_dec (
    .en  (gnt_valid),
    .sel (gnt_id_q),
    .y   (grant)
  );

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// Randomized and directed checks of rr_dec_arbiter against a behavioural model.
module tb_rr_dec_arbiter;

  localparam int MAX_HOLD = 8;
  localparam int FAIR_LIM = 4 * (MAX_HOLD + 2);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner (-1 when none), last served, grant age, turnaround left.
  int m_owner, m_last_served, m_last_id, m_held, m_cool;
  bit m_to;

  always #5 clk = ~clk;

  rr_dec_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .grant     (grant),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner       = -1;
    m_last_served = 3;
    m_last_id     = 0;
    m_held        = 0;
    m_cool        = 0;
    m_to          = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic [3:0] r);
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (!e || !r[m_owner]) begin
        m_owner = -1;
        m_cool  = 1;
      end else if (m_held == MAX_HOLD) begin
        m_owner = -1;
        m_cool  = 1;
        m_to    = 1'b1;
      end else begin
        m_held++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (e && r != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        if (m_owner < 0 && r[(m_last_served + k) % 4]) m_owner = (m_last_served + k) % 4;
      end
      m_last_served = m_owner;
      m_last_id     = m_owner;
      m_held        = 1;
    end
  endtask

  task automatic compare_all();
    logic [3:0] eg;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check_eq("grant", grant, eg);
    check_eq("gnt_id", gnt_id, m_last_id);
    check_eq("gnt_valid", gnt_valid, m_owner >= 0);
    check_eq("timeout", timeout, m_to);
  endtask

  task automatic cyc(input logic e, input logic [3:0] r);
    en  = e;
    req = r;
    @(posedge clk);
    model_step(e, r);
    #1;
    compare_all();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    req   = '0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input logic e, input logic [3:0] r, input int excl);
    for (int n = 0; n < 30; n++) begin
      cyc(e, r);
      if (gnt_valid && int'(gnt_id) != excl) break;
    end
    check_eq("wait_grant", gnt_valid, 1);
  endtask

  initial begin
    int         order[$];
    int         run_len;
    bit         prev_valid;
    int         wait_c[4];
    bit         starve;
    logic       e;
    logic [3:0] r;

    // Single requester, 1-cycle latency, release on drop, gap then idle.
    apply_reset();
    cyc(1'b1, 4'b0001);
    check_eq("first_grant", grant, 4'b0001);
    check_eq("first_id", gnt_id, 0);
    cyc(1'b1, 4'b0000);
    check_eq("drop_release", grant, 4'b0000);
    cyc(1'b1, 4'b0000);
    cyc(1'b1, 4'b0000);

    // All requesting: rotation 0,1,2,3,0 with full-length holds ending in timeout.
    apply_reset();
    prev_valid = 1'b0;
    run_len    = 0;
    for (int n = 0; n < 50; n++) begin
      cyc(1'b1, 4'b1111);
      if (gnt_valid && !prev_valid) order.push_back(int'(gnt_id));
      if (gnt_valid) run_len++;
      if (!gnt_valid && prev_valid) begin
        check_eq("hold_len", run_len, MAX_HOLD);
        check_eq("timeout_pulse", timeout, 1);
        run_len = 0;
      end
      prev_valid = gnt_valid;
    end
    check_eq("rot_count", order.size(), 5);
    for (int i = 0; i < order.size() && i < 5; i++) check_eq("rot_order", order[i], i % 4);

    // Served owner 2 drops to lowest priority; pointer wrap after owner 3.
    apply_reset();
    cyc(1'b1, 4'b0100);
    wait_grant(1'b1, 4'b0110, 2);
    check_eq("after_2", grant, 4'b0010);
    cyc(1'b1, 4'b1000);
    wait_grant(1'b1, 4'b1000, -1);
    check_eq("grant_3", grant, 4'b1000);
    wait_grant(1'b1, 4'b1001, 3);
    check_eq("wrap_0", grant, 4'b0001);

    // Disable plus owner drop on the last hold cycle: release without timeout.
    cyc(1'b1, 4'b0010);
    wait_grant(1'b1, 4'b0010, -1);
    check_eq("grant_1", gnt_id, 1);
    for (int n = 0; n < MAX_HOLD - 1; n++) cyc(1'b1, 4'b0010);
    cyc(1'b0, 4'b0000);
    check_eq("en_off_valid", gnt_valid, 0);
    check_eq("en_off_timeout", timeout, 0);
    for (int n = 0; n < 5; n++) begin
      cyc(1'b0, 4'b1111);
      check_eq("en_off_idle", grant, 4'b0000);
    end

    // Asynchronous reset in the 5th grant cycle.
    apply_reset();
    cyc(1'b1, 4'b1111);
    for (int n = 0; n < 4; n++) cyc(1'b1, 4'b1111);
    #3 rst_n = 1'b0;
    #1;
    check_eq("async_grant", grant, 4'b0000);
    check_eq("async_valid", gnt_valid, 0);
    check_eq("async_timeout", timeout, 0);
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    cyc(1'b1, 4'b0100);
    check_eq("post_reset", grant, 4'b0100);

    // Random traffic with hold-length and fairness bounds.
    foreach (wait_c[i]) wait_c[i] = 0;
    run_len = 0;
    r = 4'($urandom);
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(3) == 0) r = 4'($urandom);
      e = ($urandom_range(15) != 0);
      cyc(e, r);
      if (gnt_valid) run_len++;
      else run_len = 0;
      check_eq("hold_bound", run_len <= MAX_HOLD, 1);
      starve = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (r[i] && e && !(gnt_valid && int'(gnt_id) == i)) wait_c[i]++;
        else wait_c[i] = 0;
        if (wait_c[i] > FAIR_LIM) starve = 1'b1;
      end
      check_eq("fair_bound", starve, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_dec_arbiter.md
Name: rr_dec_arbiter

Overview:
- 4-requester round-robin arbiter that shares one 2-to-4 decoded resource (one select line per requester).
- Holds the grant while the owner keeps requesting, forces release after a bounded hold time, and rotates priority fairly.
- The one-hot grant is produced by an enabled 2-to-4 decoder sub-module driven by the registered grant index.
- Sits between the requesting lab blocks and the shared decoded output bus.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester may hold the grant (legal range 2..255).
- CNT_W, 8, width of the hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  arbiter enable. When low, no new grant is issued and any current grant is released.
- req  input  4  request vector; bit i is requester i.
- grant  output  4  one-hot grant. All zeros when idle. Decoder output gated by gnt_valid.
- gnt_id  output  2  encoded index of the current owner. Holds the last value when gnt_valid=0.
- gnt_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse in the cycle a grant is force-released by MAX_HOLD.

Behaviour:
- Reset values (async, rst_n=0): state=IDLE, grant=4'b0000, gnt_id=2'd0, gnt_valid=0, timeout=0, priority pointer ptr=2'd0, hold count cnt=0.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If en=1 and req!=0, select the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next edge: gnt_id=selected, gnt_valid=1, cnt=0, ptr=selected+1 (mod 4, 2-bit wrap), state=GRANT.
  - Latency is 1 cycle from req sampled to grant visible.
- GRANT:
  - Each edge with req[gnt_id]=1, en=1 and cnt<MAX_HOLD-1: cnt increments and the grant is kept.
  - Release conditions: req[gnt_id]=0, or en=0, or cnt==MAX_HOLD-1 with req still high.
  - On release, at the next edge: gnt_valid=0, grant=0000, state=GAP.
  - timeout=1 for exactly that cycle, and only in the MAX_HOLD case.
  - Grant therefore lasts at most MAX_HOLD cycles.
- GAP: exactly one cycle with no grant (bus turnaround), then IDLE. Arbitration resumes in IDLE, so the minimum grant-to-grant spacing is 2 idle cycles.
- Precedence when events coincide: en=0 takes precedence over a simultaneous drop or timeout. timeout is not asserted if en=0 or req[gnt_id]=0 in the same cycle.
- Changes to req bits other than the owner's have no effect during GRANT or GAP.
- The pointer updates only when a grant is issued. A requester that has just been served is lowest priority at the next arbitration.
- Reset mid-grant: outputs clear immediately (asynchronous), with no timeout pulse. The first post-reset grant searches from ptr=0.
- grant = decode(gnt_id) when gnt_valid=1, else 0000. Never more than one bit set, checked by assertion.
- cnt saturates and never wraps. ptr wraps 3->0.

Decomposition:
- Shared package arb_pkg:
  - state enum {IDLE, GRANT, GAP}.
  - constant N_REQ=4.
  - function next_owner(req, ptr) returning the 2-bit index.
- Sub-module dec2to4_en:
  - Inputs: en, sel[1:0]. Output: y[3:0].
  - Purely combinational; y = en ? (1<<sel) : 0.
  - Instantiated once with en=gnt_valid.

Test Plan:
- Reset, then req=0001, en=1 -> grant=0001 on the 2nd edge, gnt_id=0. Drop req -> grant=0000 the next edge, then GAP, IDLE.
- req=1111 held constant, MAX_HOLD=8 -> grants rotate 0001, 0010, 0100, 1000, 0001. Each lasts 8 cycles and ends with a timeout pulse. 2-cycle gaps between grants.
- Owner 2 granted, req=0110 held -> after release the next grant is 0010. Pointer wrap check: owner 3 released with req=1001 -> next grant 0001.
- During GRANT of id 1, drive en=0 and drop req[1] in the same cycle -> release next edge, timeout=0. With en=0 and req=1111 in IDLE -> no grant.
- Assert rst_n=0 asynchronously mid-grant at cycle 5 of 8 -> grant=0000, gnt_valid=0 immediately. After release with req=0100 -> grant 0100 (search from ptr=0).
- Random req/en for 10k cycles -> grant always one-hot-or-zero, no grant exceeds MAX_HOLD cycles, every persistently requesting input is granted within 4*(MAX_HOLD+2) cycles.
